// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter with a configurable bit order and bit period.
// Idle line level is 1. All outputs are registered.
module serial_word_tx #(
  parameter int NUM_BITS     = 8,
  parameter int SHIFT_MSB    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_valid,
  input  logic [NUM_BITS-1:0] load_data,
  input  logic                tx_abort,
  output logic                load_ready,
  output logic                serial_out,
  output logic                tx_active,
  output logic                tx_done
);

  localparam int BIT_W = $clog2(NUM_BITS + 1);
  localparam int PER_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);
  localparam logic [PER_W-1:0] LAST_PER = PER_W'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [PER_W-1:0]    per_cnt;

  logic                head_bit;
  logic [NUM_BITS-1:0] shifted;
  logic                load_first;
  logic [NUM_BITS-1:0] load_rest;

  // The first bit goes straight to serial_out on acceptance, so the register holds only what remains.
  always_comb begin
    if (SHIFT_MSB != 0) begin
      head_bit   = shift_reg[NUM_BITS-1];
      shifted    = {shift_reg[NUM_BITS-2:0], 1'b1};
      load_first = load_data[NUM_BITS-1];
      load_rest  = {load_data[NUM_BITS-2:0], 1'b1};
    end else begin
      head_bit   = shift_reg[0];
      shifted    = {1'b1, shift_reg[NUM_BITS-1:1]};
      load_first = load_data[0];
      load_rest  = {1'b1, load_data[NUM_BITS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_reg  <= '1;
      bit_cnt    <= '0;
      per_cnt    <= '0;
      serial_out <= 1'b1;
      load_ready <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_done <= 1'b0;
          if (load_valid && !tx_abort) begin
            state      <= SHIFT;
            shift_reg  <= load_rest;
            serial_out <= load_first;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            load_ready <= 1'b0;
            tx_active  <= 1'b1;
          end
        end
        SHIFT: begin
          if (tx_abort) begin
            state      <= IDLE;
            shift_reg  <= '1;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            serial_out <= 1'b1;
            load_ready <= 1'b1;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
          end else if (per_cnt == LAST_PER) begin
            per_cnt <= '0;
            // Last period of the last bit: the next cycle is the single tx_done idle cycle.
            if (bit_cnt == LAST_BIT) begin
              state      <= IDLE;
              shift_reg  <= '1;
              bit_cnt    <= '0;
              serial_out <= 1'b1;
              load_ready <= 1'b1;
              tx_active  <= 1'b0;
              tx_done    <= 1'b1;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              serial_out <= head_bit;
              shift_reg  <= shifted;
            end
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: three instances (MSB-first, LSB-first, 3 clocks per bit) share one stimulus
// stream and are checked every cycle against a word-level model plus hand-computed literal streams.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       tx_abort;
  logic       ser[3];
  logic       rdy[3];
  logic       act[3];
  logic       dn[3];

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit check_en  = 1'b0;

  serial_word_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(1)) u_msb (
    .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_data(load_data), .tx_abort(tx_abort),
    .load_ready(rdy[0]), .serial_out(ser[0]), .tx_active(act[0]), .tx_done(dn[0]));

  serial_word_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(1)) u_lsb (
    .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_data(load_data), .tx_abort(tx_abort),
    .load_ready(rdy[1]), .serial_out(ser[1]), .tx_active(act[1]), .tx_done(dn[1]));

  serial_word_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(3)) u_slow (
    .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_data(load_data), .tx_abort(tx_abort),
    .load_ready(rdy[2]), .serial_out(ser[2]), .tx_active(act[2]), .tx_done(dn[2]));

  always #5 clk = ~clk;

  // Word-level model: k is the 1-based cycle number within the word currently on the line.
  typedef struct {
    bit         busy;
    bit         done;
    int         k;
    logic [7:0] word;
  } model_t;

  model_t m[3];

  function automatic int cpb(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic bit msb_first(input int i);
    return i != 1;
  endfunction

  function automatic logic exp_bit(input int i);
    int idx;
    idx = (m[i].k - 1) / cpb(i);
    return msb_first(i) ? m[i].word[7 - idx] : m[i].word[idx];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      model_t nx;
      nx = m[i];
      if (!n_rst) begin
        nx.busy = 1'b0;
        nx.done = 1'b0;
      end else if (m[i].busy) begin
        if (tx_abort) begin
          nx.busy = 1'b0;
          nx.done = 1'b0;
        end else if (m[i].k == 8 * cpb(i)) begin
          nx.busy = 1'b0;
          nx.done = 1'b1;
        end else begin
          nx.k = m[i].k + 1;
        end
      end else begin
        nx.done = 1'b0;
        if (load_valid && !tx_abort) begin
          nx.busy = 1'b1;
          nx.k    = 1;
          nx.word = load_data;
        end
      end
      m[i] <= nx;
    end
  end

  task automatic check_output(input string name, input logic got, input logic expv);
    check_cnt++;
    if (got === expv) pass_cnt++;
    else $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, expv);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        check_output($sformatf("model u%0d serial_out", i), ser[i], m[i].busy ? exp_bit(i) : 1'b1);
        check_output($sformatf("model u%0d load_ready", i), rdy[i], !m[i].busy);
        check_output($sformatf("model u%0d tx_active", i), act[i], m[i].busy);
        check_output($sformatf("model u%0d tx_done", i), dn[i], !m[i].busy && m[i].done);
      end
    end
  end

  // Each call occupies one cycle: the inputs are sampled at the rising edge that ends it.
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic a, input logic r);
    @(negedge clk);
    load_valid = v;
    load_data  = d;
    tx_abort   = a;
    n_rst      = r;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  logic [7:0]  msb_c1;
  logic [7:0]  lsb_c1;
  logic [23:0] a5_slow;
  logic [7:0]  w0f;
  logic [7:0]  wf0;
  logic [7:0]  w81;

  initial begin
    msb_c1  = 8'b1100_0001;
    lsb_c1  = 8'b1000_0011;
    a5_slow = 24'b111_000_111_000_000_111_000_111;
    w0f     = 8'b0000_1111;
    wf0     = 8'b1111_0000;
    w81     = 8'b1000_0001;

    n_rst = 1'b0; load_valid = 1'b0; load_data = 8'h00; tx_abort = 1'b0;
    @(posedge clk);
    check_en = 1'b1;
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("reset serial_out", ser[0], 1'b1);
    check_output("reset load_ready", rdy[0], 1'b1);
    check_output("reset tx_active", act[0], 1'b0);
    check_output("reset tx_done", dn[0], 1'b0);
    idle_cycles(2);

    // 0xC1 on the MSB-first and LSB-first instances
    apply_stimulus(1'b1, 8'hC1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output($sformatf("C1 msb bit cycle %0d", i), ser[0], msb_c1[8-i]);
      check_output($sformatf("C1 lsb bit cycle %0d", i), ser[1], lsb_c1[8-i]);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("C1 msb tx_done cycle 9", dn[0], 1'b1);
    check_output("C1 lsb tx_done cycle 9", dn[1], 1'b1);
    check_output("C1 msb idle level cycle 9", ser[0], 1'b1);
    idle_cycles(20);

    // 0xA5 at three clocks per bit
    apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output($sformatf("A5 slow bit cycle %0d", i), ser[2], a5_slow[24-i]);
      check_output($sformatf("A5 slow load_ready cycle %0d", i), rdy[2], 1'b0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("A5 slow tx_done cycle 25", dn[2], 1'b1);
    check_output("A5 slow load_ready cycle 25", rdy[2], 1'b1);
    idle_cycles(4);

    // Back-to-back words with load_valid held high and data changing mid-word
    apply_stimulus(1'b1, 8'h0F, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, 8'hF0, 1'b0, 1'b1);
      check_output($sformatf("0F msb bit cycle %0d", i), ser[0], w0f[8-i]);
    end
    apply_stimulus(1'b1, 8'hF0, 1'b0, 1'b1);
    check_output("0F tx_done cycle 9", dn[0], 1'b1);
    check_output("0F idle gap cycle 9", ser[0], 1'b1);
    check_output("0F load_ready cycle 9", rdy[0], 1'b1);
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output($sformatf("F0 msb bit cycle %0d", i + 9), ser[0], wf0[8-i]);
      if (i == 1) check_output("F0 tx_done low cycle 10", dn[0], 1'b0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("F0 tx_done cycle 18", dn[0], 1'b1);
    idle_cycles(20);

    // Abort at cycle 4, abort-vs-accept priority in IDLE, then a normal word
    apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b1);
    idle_cycles(3);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 5; i <= 11; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output($sformatf("abort serial_out cycle %0d", i), ser[0], 1'b1);
      check_output($sformatf("abort load_ready cycle %0d", i), rdy[0], 1'b1);
      check_output($sformatf("abort tx_done cycle %0d", i), dn[0], 1'b0);
    end
    apply_stimulus(1'b1, 8'h81, 1'b1, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("abort beats accept load_ready", rdy[0], 1'b1);
    check_output("abort beats accept tx_active", act[0], 1'b0);
    apply_stimulus(1'b1, 8'h81, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output($sformatf("81 msb bit cycle %0d", i), ser[0], w81[8-i]);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("81 tx_done cycle 9", dn[0], 1'b1);
    idle_cycles(20);

    // Reset at cycle 3 of a word, together with abort and load_valid
    apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    idle_cycles(2);
    apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("midword reset serial_out", ser[0], 1'b1);
    check_output("midword reset load_ready", rdy[0], 1'b1);
    check_output("midword reset tx_active", act[0], 1'b0);
    check_output("midword reset tx_done", dn[0], 1'b0);
    check_output("midword reset slow tx_active", act[2], 1'b0);
    for (int i = 5; i <= 14; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output($sformatf("post reset serial_out cycle %0d", i), ser[0], 1'b1);
      check_output($sformatf("post reset tx_done cycle %0d", i), dn[0], 1'b0);
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter: NUM_BITS, 8, word width in bits; legal range is 2 or more.
REQ-002 Parameter: SHIFT_MSB, 1, bit order: 1 = MSB first, 0 = LSB first.
REQ-003 Parameter: CLKS_PER_BIT, 1, clock cycles each bit is held on serial_out; legal range is 1 or more.
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: n_rst  input  1  reset, synchronous and active-low.
REQ-006 Port: load_valid  input  1  producer offers load_data this cycle.
REQ-007 Port: load_data  input  NUM_BITS  parallel word to transmit.
REQ-008 Port: tx_abort  input  1  synchronous cancel of the word in flight.
REQ-009 Port: load_ready  output  1  block can accept a word this cycle.
REQ-010 Port: serial_out  output  1  serial bit stream; idle level is 1.
REQ-011 Port: tx_active  output  1  high while a word is being shifted out.
REQ-012 Port: tx_done  output  1  one-cycle pulse after the last bit period completes.

Function
REQ-013 All outputs SHALL be driven from registers, with no combinational path from any input to any output.
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 In IDLE: load_ready=1, tx_active=0, serial_out=1.
REQ-016 Acceptance SHALL occur on a rising edge where load_valid=1 and load_ready=1; load_data is captured into the shift register and the FSM enters SHIFT.
REQ-017 The first data bit SHALL appear on serial_out in the cycle after acceptance; latency is 1 cycle.
REQ-018 First bit SHALL be load_data[NUM_BITS-1] when SHIFT_MSB=1, and load_data[0] when SHIFT_MSB=0.
REQ-019 Each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-020 The word SHALL occupy NUM_BITS*CLKS_PER_BIT consecutive SHIFT cycles, in order.
REQ-021 Counter widths: bit counter is $clog2(NUM_BITS+1) bits; period counter is $clog2(CLKS_PER_BIT+1) bits.
REQ-022 Both counters SHALL clear on acceptance and SHALL never wrap during a word.
REQ-023 In SHIFT: load_ready=0 and tx_active=1; load_valid and load_data are ignored.
REQ-024 After the last cycle of the last bit, the FSM SHALL return to IDLE with serial_out=1 and tx_done=1 for exactly that first IDLE cycle.
REQ-025 A word may be accepted in the same cycle tx_done is high, giving back-to-back words with exactly one idle cycle (serial_out=1) between them.
REQ-026 tx_abort=1 in SHIFT SHALL force IDLE on the next edge: serial_out=1, load_ready=1, counters cleared, no tx_done pulse.
REQ-027 tx_abort=1 in IDLE SHALL have no effect; tx_abort has priority over acceptance in the same cycle, so no word is accepted.
REQ-028 tx_done SHALL never be high in two consecutive cycles.

Reset
REQ-029 When n_rst=0 at a rising edge, the block SHALL enter IDLE: serial_out=1, load_ready=1, tx_active=0, tx_done=0, shift register all-ones, counters zero.
REQ-030 Reset SHALL take priority over all other inputs, including mid-word and in the same cycle as tx_abort or acceptance.
REQ-031 No partial word or tx_done SHALL be emitted after reset deasserts.

Verification
REQ-032 MSB-first, CLKS_PER_BIT=1, accept 0xC1 at cycle 0 -> serial_out = 1,1,0,0,0,0,0,1 in cycles 1-8; tx_done=1 at cycle 9.
REQ-033 SHIFT_MSB=0, accept 0xC1 -> serial_out = 1,0,0,0,0,0,1,1 in cycles 1-8; tx_done at cycle 9.
REQ-034 CLKS_PER_BIT=3, accept 0xA5 -> each bit held 3 cycles over cycles 1-24; tx_done at cycle 25; load_ready=0 throughout cycles 1-24.
REQ-035 load_valid held high with words 0x0F then 0xF0 -> second word accepted in the tx_done cycle; one idle 1 between words; load_valid pulses during SHIFT do not alter the stream.
REQ-036 tx_abort at cycle 4 of a word -> serial_out=1, load_ready=1, and no tx_done from cycle 5; a new word is accepted normally afterwards.
REQ-037 n_rst=0 at cycle 3 of a word -> all outputs at reset values next cycle; after release, only serial_out=1 until a new acceptance.
